// File: rtl/power_rail_sequencer.sv
// power_rail_sequencer: N-rail ordered power-up / power-down sequencer for one
// supply domain. Rails come up in ascending order, each gated on its power-good
// plus a settle delay, and go down in descending order with an inter-rail gap.
// Any power-good loss or ramp timeout drops every rail at once and latches a fault.
module power_rail_sequencer #(
    parameter int unsigned NUM_RAILS         = 4,
    parameter int unsigned CNT_WIDTH         = 16,
    parameter int unsigned SETTLE_CYCLES     = 1600,
    parameter int unsigned PG_TIMEOUT_CYCLES = 8000,
    parameter int unsigned OFF_DELAY_CYCLES  = 800,
    localparam int unsigned IDX_W            = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_RAILS-1:0] rail_good,
    output logic [NUM_RAILS-1:0] rail_en,
    output logic                 power_good,
    output logic                 up_pulse,
    output logic                 fault,
    output logic [IDX_W-1:0]     fault_rail,
    output logic [IDX_W-1:0]     stage,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_RAMP   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_UP     = 3'd3,
        ST_DOWN   = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    localparam logic [IDX_W-1:0]     LAST_STAGE = IDX_W'(NUM_RAILS - 1);
    localparam logic [CNT_WIDTH-1:0] SETTLE_END = CNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_END = CNT_WIDTH'(PG_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] OFF_END    = CNT_WIDTH'(OFF_DELAY_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       stage_q, stage_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [NUM_RAILS-1:0]   rail_en_q, rail_en_d;
    logic                   pg_q, pg_d;
    logic                   up_q, up_d;
    logic                   fault_q, fault_d;
    logic [IDX_W-1:0]       fault_rail_q, fault_rail_d;

    logic                   mon_active;
    logic                   mon_incl_cur;
    logic                   mon_fail;
    logic [IDX_W-1:0]       mon_idx;
    logic                   cur_good;
    logic                   ramp_timeout;

    // Power-good monitor: lowest-index enabled rail that has lost good.
    // In RAMP the current rail is still coming up, so only rails below it count.
    always_comb begin
        mon_active   = (state_q == ST_RAMP) || (state_q == ST_SETTLE) || (state_q == ST_UP);
        mon_incl_cur = (state_q == ST_SETTLE) || (state_q == ST_UP);
        mon_fail     = 1'b0;
        mon_idx      = '0;
        for (int j = 0; j < int'(NUM_RAILS); j++) begin
            if (mon_active && !mon_fail && !rail_good[j] &&
                ((IDX_W'(j) < stage_q) || (mon_incl_cur && (IDX_W'(j) == stage_q)))) begin
                mon_fail = 1'b1;
                mon_idx  = IDX_W'(j);
            end
        end
    end

    // Current-rail good and ramp timeout detection.
    always_comb begin
        cur_good     = rail_good[stage_q];
        ramp_timeout = (state_q == ST_RAMP) && !cur_good && (cnt_q == TIMEOUT_END);
    end

    // Next-state and registered-output logic. Priority: fault, then enable drop,
    // then normal progress.
    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        cnt_d        = cnt_q;
        rail_en_d    = rail_en_q;
        pg_d         = pg_q;
        up_d         = 1'b0;
        fault_d      = fault_q;
        fault_rail_d = fault_rail_q;

        case (state_q)
            ST_OFF: begin
                if (enable) begin
                    state_d   = ST_RAMP;
                    stage_d   = '0;
                    cnt_d     = '0;
                    rail_en_d = NUM_RAILS'(1);
                end
            end

            ST_RAMP, ST_SETTLE, ST_UP: begin
                if (mon_fail || ramp_timeout) begin
                    state_d      = ST_FAULT;
                    rail_en_d    = '0;
                    pg_d         = 1'b0;
                    fault_d      = 1'b1;
                    cnt_d        = '0;
                    fault_rail_d = mon_fail ? mon_idx : stage_q;
                end else if (!enable) begin
                    // Orderly shutdown starts with the highest rail enabled so far
                    state_d            = ST_DOWN;
                    pg_d               = 1'b0;
                    cnt_d              = '0;
                    rail_en_d[stage_q] = 1'b0;
                end else if (state_q == ST_RAMP) begin
                    if (cur_good) begin
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end else if (state_q == ST_SETTLE) begin
                    if (cnt_q == SETTLE_END) begin
                        cnt_d = '0;
                        if (stage_q == LAST_STAGE) begin
                            state_d = ST_UP;
                            pg_d    = 1'b1;
                            up_d    = 1'b1;
                        end else begin
                            state_d                         = ST_RAMP;
                            stage_d                         = stage_q + IDX_W'(1);
                            rail_en_d[stage_q + IDX_W'(1)]  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end

            ST_DOWN: begin
                // Power-good is ignored here; rails are expected to fall
                if (cnt_q == OFF_END) begin
                    cnt_d = '0;
                    if (stage_q != '0) begin
                        stage_d                         = stage_q - IDX_W'(1);
                        rail_en_d[stage_q - IDX_W'(1)]  = 1'b0;
                    end else begin
                        state_d = ST_OFF;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end

            ST_FAULT: begin
                rail_en_d = '0;
                pg_d      = 1'b0;
                if (!enable) begin
                    state_d = ST_OFF;
                    fault_d = 1'b0;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d   = ST_OFF;
                rail_en_d = '0;
                pg_d      = 1'b0;
                cnt_d     = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q      <= ST_OFF;
            stage_q      <= '0;
            cnt_q        <= '0;
            rail_en_q    <= '0;
            pg_q         <= 1'b0;
            up_q         <= 1'b0;
            fault_q      <= 1'b0;
            fault_rail_q <= '0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            cnt_q        <= cnt_d;
            rail_en_q    <= rail_en_d;
            pg_q         <= pg_d;
            up_q         <= up_d;
            fault_q      <= fault_d;
            fault_rail_q <= fault_rail_d;
        end
    end

    assign rail_en    = rail_en_q;
    assign power_good = pg_q;
    assign up_pulse   = up_q;
    assign fault      = fault_q;
    assign fault_rail = fault_rail_q;
    assign stage      = stage_q;
    assign state      = state_q;

endmodule
